i2c_target_regs: RTL and testbench

//  I2C target (responder) exposing a small 8-bit register bank to an external I2C master.

---
 rtl/i2c_target_regs.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match and an
// auto-incrementing register pointer into an external 8-bit register bank.
module i2c_target_regs #(
    parameter logic [6:0] I2C_ADDR    = 7'h50,
    parameter int         NREGS       = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        PW          = $clog2(NREGS)
) (
    input  logic          i_clk,
    input  logic          i_aresetn,
    input  logic          i_scl,
    input  logic          i_sda,
    output logic          o_sda_t,
    output logic [PW-1:0] o_reg_addr,
    output logic [7:0]    o_reg_wdata,
    output logic          o_reg_wr,
    output logic          o_reg_rd,
    input  logic [7:0]    i_reg_rdata,
    output logic          o_busy
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
        StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
    } state_e;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_prev, r_sda_prev;
    state_e                 r_state;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_shift;
    logic                   r_rw;
    logic                   r_load;
    logic                   r_sda_t;
    logic [PW-1:0]          r_reg_addr;
    logic [7:0]             r_reg_wdata;
    logic                   r_reg_wr, r_reg_rd, r_busy;

    logic       w_scl_s, w_sda_s;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;

    assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl_s & ~r_scl_prev;
    assign w_scl_fall = ~w_scl_s & r_scl_prev;
    // SCL must be high on both samples so an SCL edge never reads as START/STOP
    assign w_start    = w_scl_s & r_scl_prev & r_sda_prev & ~w_sda_s;
    assign w_stop     = w_scl_s & r_scl_prev & ~r_sda_prev & w_sda_s;
    assign w_byte     = {r_shift[6:0], w_sda_s};

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= w_scl_s;
            r_sda_prev <= w_sda_s;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state     <= StIdle;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_rw        <= 1'b0;
            r_load      <= 1'b0;
            r_sda_t     <= 1'b1;
            r_reg_addr  <= '0;
            r_reg_wdata <= 8'h00;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_reg_wr <= 1'b0;
            r_reg_rd <= 1'b0;
            r_load   <= r_reg_rd;
            if (r_load) begin
                r_shift <= i_reg_rdata;
            end

            if (w_start) begin
                r_state  <= StAddr;
                r_bitcnt <= 3'd0;
                r_sda_t  <= 1'b1;
            end else if (w_stop) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
                r_sda_t <= 1'b1;
            end else begin
                unique case (r_state)
                    StIdle: ;
                    StAddr, StPtr, StWdata: begin
                        if (w_scl_fall) begin
                            r_sda_t <= 1'b1;
                        end
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                unique case (r_state)
                                    StAddr: begin
                                        if (r_shift[6:0] == I2C_ADDR) begin
                                            r_state <= StAddrAck;
                                            r_rw    <= w_sda_s;
                                            r_busy  <= 1'b1;
                                        end else begin
                                            r_state <= StIgnore;
                                            r_busy  <= 1'b0;
                                        end
                                    end
                                    StPtr: begin
                                        r_reg_addr <= w_byte[PW-1:0];
                                        r_state    <= StPtrAck;
                                    end
                                    default: begin
                                        r_reg_wdata <= w_byte;
                                        r_reg_wr    <= 1'b1;
                                        r_state     <= StWdataAck;
                                    end
                                endcase
                            end
                        end
                    end
                    StAddrAck, StPtrAck, StWdataAck: begin
                        // Fall ending the 8th bit starts the ACK; the ACK rise moves on
                        if (w_scl_fall) begin
                            r_sda_t <= 1'b0;
                        end
                        if (w_scl_rise) begin
                            r_bitcnt <= 3'd0;
                            if (r_state == StAddrAck) begin
                                if (r_rw) begin
                                    r_state  <= StRdata;
                                    r_reg_rd <= 1'b1;
                                end else begin
                                    r_state <= StPtr;
                                end
                            end else begin
                                if (r_state == StWdataAck) begin
                                    r_reg_addr <= r_reg_addr + PW'(1);
                                end
                                r_state <= StWdata;
                            end
                        end
                    end
                    StRdata: begin
                        if (w_scl_fall) begin
                            r_sda_t <= r_shift[7];
                        end
                        if (w_scl_rise) begin
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_state <= StRdataAck;
                            end
                        end
                    end
                    StRdataAck: begin
                        if (w_scl_fall) begin
                            r_sda_t <= 1'b1;
                        end
                        if (w_scl_rise) begin
                            r_reg_addr <= r_reg_addr + PW'(1);
                            r_bitcnt   <= 3'd0;
                            if (!w_sda_s) begin
                                r_reg_rd <= 1'b1;
                                r_state  <= StRdata;
                            end else begin
                                r_state <= StIgnore;
                            end
                        end
                    end
                    StIgnore: begin
                        if (w_scl_fall) begin
                            r_sda_t <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_sda_t <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_sda_t     = r_sda_t;
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_reg_wdata;
    assign o_reg_wr    = r_reg_wr;
    assign o_reg_rd    = r_reg_rd;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C master on an open-drain SDA bus
// and a small register-bank model behind the target.
module tb_i2c_target_regs;

    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_t;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr, reg_rd, busy;
    logic [7:0] reg_rdata;
    logic       bus_sda;
    logic [7:0] mem [16];

    int vectors = 0;
    int miscompares = 0;

    assign bus_sda   = m_sda & sda_t;
    assign reg_rdata = mem[reg_addr];

    always #5 clk = ~clk;

    i2c_target_regs #(
        .I2C_ADDR    (7'h50),
        .NREGS       (16),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk       (clk),
        .i_aresetn   (aresetn),
        .i_scl       (m_scl),
        .i_sda       (bus_sda),
        .o_sda_t     (sda_t),
        .o_reg_addr  (reg_addr),
        .o_reg_wdata (reg_wdata),
        .o_reg_wr    (reg_wr),
        .o_reg_rd    (reg_rd),
        .i_reg_rdata (reg_rdata),
        .o_busy      (busy)
    );

    // Strobe capture, SDA-drive counting and SCL-high stability monitor
    logic [11:0] wr_q [$];
    logic [3:0]  rd_q [$];
    int          drive_cnt = 0;
    int          busy_cnt = 0;
    int          viol = 0;
    logic [5:0]  scl_hist = '0;
    logic        sda_t_prev = 1'b1;

    always @(negedge clk) begin
        if (reg_wr) wr_q.push_back({reg_addr, reg_wdata});
        if (reg_rd) rd_q.push_back(reg_addr);
        if (sda_t === 1'b0) drive_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (aresetn && (sda_t !== sda_t_prev) && (&scl_hist)) viol++;
        sda_t_prev = sda_t;
        scl_hist   = {scl_hist[4:0], m_scl};
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        wait_clks(Q);
        m_scl = 1'b1;
        wait_clks(Q);
        m_sda = 1'b0;
        wait_clks(Q);
        m_scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        wait_clks(Q);
        m_scl = 1'b1;
        wait_clks(Q);
        m_sda = 1'b1;
        wait_clks(Q);
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        if (glitch) begin
            repeat (3) begin
                m_sda = ~b;
                wait_clks(2);
                m_sda = b;
                wait_clks(2);
            end
        end
        m_sda = b;
        wait_clks(Q);
        m_scl = 1'b1;
        wait_clks(2 * Q);
        m_scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1;
        wait_clks(Q);
        m_scl = 1'b1;
        wait_clks(Q);
        b = bus_sda;
        wait_clks(Q);
        m_scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic glitch, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i], glitch);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~master_ack, 1'b0);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        m_scl = 1'b1;
        m_sda = 1'b1;
        wait_clks(3);
        vectors++; if (sda_t !== 1'b1) begin miscompares++; $display("FAIL reset_sda_t: got %b want 1", sda_t); end
        vectors++; if (reg_addr !== 4'h0) begin miscompares++; $display("FAIL reset_reg_addr: got %h want 0", reg_addr); end
        vectors++; if (reg_wdata !== 8'h00) begin miscompares++; $display("FAIL reset_reg_wdata: got %h want 00", reg_wdata); end
        vectors++; if (reg_wr !== 1'b0) begin miscompares++; $display("FAIL reset_reg_wr: got %b want 0", reg_wr); end
        vectors++; if (reg_rd !== 1'b0) begin miscompares++; $display("FAIL reset_reg_rd: got %b want 0", reg_rd); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        aresetn = 1'b1;
        wait_clks(Q);
    endtask

    task automatic test_write();
        logic [7:0] d;
        logic       a0, a1, a2, a3;
        int         wb;
        wb = wr_q.size();
        d  = 8'hA0;
        i2c_start();
        write_byte(d, 1'b0, a0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL write_busy_after_addr: got %b want 1", busy); end
        write_byte(8'h03, 1'b0, a1);
        write_byte(8'h11, 1'b0, a2);
        write_byte(8'h22, 1'b0, a3);
        i2c_stop();
        wait_clks(4);
        vectors++; if ({a0, a1, a2, a3} !== 4'b1111) begin miscompares++; $display("FAIL write_acks: got %b want 1111", {a0, a1, a2, a3}); end
        vectors++; if (wr_q.size() - wb !== 2) begin miscompares++; $display("FAIL write_strobe_count: got %0d want 2", wr_q.size() - wb); end
        vectors++; if (wr_q[wb] !== 12'h311) begin miscompares++; $display("FAIL write_first: got %h want 311", wr_q[wb]); end
        vectors++; if (wr_q[wb+1] !== 12'h422) begin miscompares++; $display("FAIL write_second: got %h want 422", wr_q[wb+1]); end
        vectors++; if (reg_addr !== 4'h5) begin miscompares++; $display("FAIL write_final_addr: got %h want 5", reg_addr); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_read();
        logic [7:0] d0, d1;
        logic       a0, a1, a2;
        int         rb, wb;
        rb = rd_q.size();
        wb = wr_q.size();
        mem[5] = 8'h5A;
        mem[6] = 8'hC3;
        i2c_start();
        write_byte(8'hA0, 1'b0, a0);
        write_byte(8'h05, 1'b0, a1);
        i2c_start();
        write_byte(8'hA1, 1'b0, a2);
        read_byte(1'b1, d0);
        read_byte(1'b0, d1);
        i2c_stop();
        wait_clks(4);
        vectors++; if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL read_acks: got %b want 111", {a0, a1, a2}); end
        vectors++; if (d0 !== 8'h5A) begin miscompares++; $display("FAIL read_byte0: got %h want 5a", d0); end
        vectors++; if (d1 !== 8'hC3) begin miscompares++; $display("FAIL read_byte1: got %h want c3", d1); end
        vectors++; if (rd_q.size() - rb !== 2) begin miscompares++; $display("FAIL read_strobe_count: got %0d want 2", rd_q.size() - rb); end
        vectors++; if (rd_q[rb] !== 4'h5) begin miscompares++; $display("FAIL read_strobe0_addr: got %h want 5", rd_q[rb]); end
        vectors++; if (rd_q[rb+1] !== 4'h6) begin miscompares++; $display("FAIL read_strobe1_addr: got %h want 6", rd_q[rb+1]); end
        vectors++; if (reg_addr !== 4'h7) begin miscompares++; $display("FAIL read_final_addr: got %h want 7", reg_addr); end
        vectors++; if (wr_q.size() !== wb) begin miscompares++; $display("FAIL read_no_writes: got %0d want %0d", wr_q.size(), wb); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL read_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        int   wb, rb, db, bb;
        wb = wr_q.size();
        rb = rd_q.size();
        db = drive_cnt;
        bb = busy_cnt;
        i2c_start();
        write_byte(8'hA2, 1'b0, a0);
        write_byte(8'h00, 1'b0, a1);
        i2c_stop();
        wait_clks(4);
        vectors++; if ({a0, a1} !== 2'b00) begin miscompares++; $display("FAIL wrong_addr_nacks: got %b want 00", {a0, a1}); end
        vectors++; if (drive_cnt !== db) begin miscompares++; $display("FAIL wrong_addr_sda_driven: got %0d cycles want 0", drive_cnt - db); end
        vectors++; if (wr_q.size() !== wb || rd_q.size() !== rb) begin miscompares++; $display("FAIL wrong_addr_strobes: got %0d wr %0d rd want 0 0", wr_q.size() - wb, rd_q.size() - rb); end
        vectors++; if (busy_cnt !== bb) begin miscompares++; $display("FAIL wrong_addr_busy: got %0d busy cycles want 0", busy_cnt - bb); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3, a4, a5;
        int   wb;
        wb = wr_q.size();
        i2c_start();
        write_byte(8'hA0, 1'b0, a0);
        write_byte(8'h0F, 1'b0, a1);
        write_byte(8'hAA, 1'b0, a2);
        write_byte(8'hBB, 1'b0, a3);
        i2c_stop();
        wait_clks(4);
        vectors++; if ({a0, a1, a2, a3} !== 4'b1111) begin miscompares++; $display("FAIL wrap_acks: got %b want 1111", {a0, a1, a2, a3}); end
        vectors++; if (wr_q[wb] !== 12'hFAA) begin miscompares++; $display("FAIL wrap_first: got %h want faa", wr_q[wb]); end
        vectors++; if (wr_q[wb+1] !== 12'h0BB) begin miscompares++; $display("FAIL wrap_second: got %h want 0bb", wr_q[wb+1]); end
        vectors++; if (reg_addr !== 4'h1) begin miscompares++; $display("FAIL wrap_addr_after: got %h want 1", reg_addr); end
        i2c_start();
        write_byte(8'hA0, 1'b0, a4);
        write_byte(8'h13, 1'b0, a5);
        i2c_stop();
        wait_clks(4);
        vectors++; if (reg_addr !== 4'h3) begin miscompares++; $display("FAIL wrap_ptr_truncate: got %h want 3", reg_addr); end
        vectors++; if (wr_q.size() - wb !== 2) begin miscompares++; $display("FAIL wrap_strobe_count: got %0d want 2", wr_q.size() - wb); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic       a0, a1, a2;
        int         wb;
        d = 8'hA0;
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(d[i], 1'b0);
        m_sda = 1'b1;
        vectors++; if (sda_t !== 1'b0) begin miscompares++; $display("FAIL rstmid_ack_driven: got %b want 0", sda_t); end
        @(posedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        vectors++; if (sda_t !== 1'b1) begin miscompares++; $display("FAIL rstmid_sda_release: got %b want 1", sda_t); end
        vectors++; if (busy !== 1'b0 || reg_addr !== 4'h0) begin miscompares++; $display("FAIL rstmid_state: got busy %b addr %h want 0 0", busy, reg_addr); end
        wait_clks(2);
        m_scl = 1'b1;
        wait_clks(Q);
        aresetn = 1'b1;
        wait_clks(Q);
        wb = wr_q.size();
        i2c_start();
        write_byte(8'hA0, 1'b0, a0);
        write_byte(8'h07, 1'b0, a1);
        write_byte(8'h5C, 1'b0, a2);
        i2c_stop();
        wait_clks(4);
        vectors++; if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL rstmid_fresh_acks: got %b want 111", {a0, a1, a2}); end
        vectors++; if (wr_q.size() - wb !== 1 || wr_q[wb] !== 12'h75C) begin miscompares++; $display("FAIL rstmid_fresh_write: got %0d strobes first %h want 1 75c", wr_q.size() - wb, wr_q[wb]); end
    endtask

    task automatic test_glitch();
        logic a0, a1, a2;
        int   wb;
        wb = wr_q.size();
        i2c_start();
        write_byte(8'hA0, 1'b1, a0);
        write_byte(8'h09, 1'b1, a1);
        write_byte(8'h77, 1'b1, a2);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_mid: got %b want 1", busy); end
        i2c_stop();
        wait_clks(4);
        vectors++; if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL glitch_acks: got %b want 111", {a0, a1, a2}); end
        vectors++; if (wr_q.size() - wb !== 1 || wr_q[wb] !== 12'h977) begin miscompares++; $display("FAIL glitch_write: got %0d strobes first %h want 1 977", wr_q.size() - wb, wr_q[wb]); end
        vectors++; if (reg_addr !== 4'hA) begin miscompares++; $display("FAIL glitch_final_addr: got %h want a", reg_addr); end
        vectors++; if (viol !== 0) begin miscompares++; $display("FAIL sda_t_stable_scl_high: got %0d changes want 0", viol); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
        test_reset();
        test_write();
        test_read();
        test_wrong_addr();
        test_wrap();
        test_reset_mid();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
